// File: rtl/video_timing_pkg.sv
// Shared definitions for the video pattern generator slice.
//   - state_e          : timing FSM states (IDLE, RUN, DRAIN)
//   - PAT_*            : pattern select codes
//   - COL_*            : 24-bit {R,G,B} colours of the eight colour bars
//   - bar_colour()     : bar index (0 = leftmost) to colour
package video_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video output bundle of the pattern generator.
//   HSync/VSync/VDE : raster timing, RGBout : {R,G,B} pixel,
//   FrameStart      : pulse on pixel (0,0), PixelX/PixelY : output pixel coordinates.
// master = the generator (drives), slave = the downstream consumer.
interface video_pattern_gen_if;
  logic        HSync;
  logic        VSync;
  logic        VDE;
  logic [23:0] RGBout;
  logic        FrameStart;
  logic [11:0] PixelX;
  logic [11:0] PixelY;

  modport master (output HSync, VSync, VDE, RGBout, FrameStart, PixelX, PixelY);
  modport slave  (input  HSync, VSync, VDE, RGBout, FrameStart, PixelX, PixelY);
endinterface

// File: rtl/video_pattern_rom.sv
// Combinational test-pattern source: (pattern, x, y[, fcnt]) -> {R,G,B}.
//   pat  : pattern code (bars / checkerboard / grey ramp / white box)
//   x, y : active-region pixel coordinates
//   fcnt : frame index, present only when PATTERN_SCROLL_EN is defined; it
//          shifts x for patterns 1..3 so the image scrolls one pixel per frame
//   rgb  : pixel colour
module video_pattern_rom
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic [1:0]  pat,
  input  logic [11:0] x,
  input  logic [11:0] y,
`ifdef PATTERN_SCROLL_EN
  input  logic [11:0] fcnt,
`endif
  output logic [23:0] rgb
);

  localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / 8);
  localparam logic [11:0] BOX_X0 = 12'(H_ACTIVE / 4);
  localparam logic [11:0] BOX_X1 = 12'((3 * H_ACTIVE) / 4);
  localparam logic [11:0] BOX_Y0 = 12'(V_ACTIVE / 4);
  localparam logic [11:0] BOX_Y1 = 12'((3 * V_ACTIVE) / 4);

  logic [11:0] xs_s;
  logic [2:0]  bar_idx_s;
  logic        in_box_s;

  // Pattern selection; the last bar index saturates at 7 so it absorbs the remainder.
  always_comb begin
`ifdef PATTERN_SCROLL_EN
    xs_s = x + fcnt;
`else
    xs_s = x;
`endif
    bar_idx_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      bar_idx_s = (x >= 12'(i * BAR_W)) ? 3'(i) : bar_idx_s;
    end
    in_box_s = (xs_s >= BOX_X0) && (xs_s < BOX_X1) && (y >= BOX_Y0) && (y < BOX_Y1);
    case (pat)
      PAT_BARS:  rgb = bar_colour(bar_idx_s);
      PAT_CHECK: rgb = (xs_s[5] ^ y[5]) ? COL_BLACK : COL_WHITE;
      PAT_RAMP:  rgb = {3{xs_s[7:0]}};
      PAT_BOX:   rgb = in_box_s ? COL_WHITE : COL_BLACK;
      default:   rgb = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Parameterised raster timing generator with deterministic test patterns.
//   CLK, RST (synchronous, active-high), Enable (stream request),
//   Pattern (2-bit select, sampled at frame start), vid (video output bundle).
// Every output is registered one cycle after the (hcnt, vcnt) it describes.
// Optional build macro: PATTERN_SCROLL_EN (per-frame horizontal scroll).
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Enable,
  input  logic [1:0]          Pattern,
  video_pattern_gen_if.master vid
);

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [1:0]  pat_q, pat_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d, fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic [11:0] px_q, px_d, py_q, py_d;

  logic        emit_s, origin_s, h_last_s, f_last_s, active_s;
  logic [1:0]  pat_sel_s;
  logic [23:0] rom_rgb_s;

`ifdef PATTERN_SCROLL_EN
  logic [11:0] fcnt_q, fcnt_d, fcnt_sel_s;
`endif

  // Cycle qualifiers: a pixel is emitted in RUN/DRAIN, or from IDLE on the cycle Enable starts a frame.
  always_comb begin
    emit_s    = (state_q == IDLE) ? Enable : 1'b1;
    origin_s  = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    h_last_s  = (hcnt_q == H_LAST);
    f_last_s  = h_last_s && (vcnt_q == V_LAST);
    active_s  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    // The origin pixel already uses the new selection so a frame never mixes patterns.
    pat_sel_s = (emit_s && origin_s) ? Pattern : pat_q;
    pat_d     = pat_sel_s;
  end

`ifdef PATTERN_SCROLL_EN
  // fcnt_q counts FrameStarts; inside a frame the started frame's index is fcnt_q - 1.
  always_comb begin
    fcnt_d     = (emit_s && origin_s) ? (fcnt_q + 12'd1) : fcnt_q;
    fcnt_sel_s = (emit_s && origin_s) ? fcnt_q : (fcnt_q - 12'd1);
  end
`endif

  // Next FSM state: a frame in flight always runs to its last pixel before IDLE.
  always_comb begin
    case (state_q)
      IDLE:    state_d = Enable ? RUN : IDLE;
      RUN:     state_d = Enable ? RUN : (f_last_s ? IDLE : DRAIN);
      DRAIN:   state_d = Enable ? RUN : (f_last_s ? IDLE : DRAIN);
      default: state_d = IDLE;
    endcase
  end

  // Raster counters advance only on emitted pixels, so IDLE holds them at (0,0).
  always_comb begin
    if (!emit_s) begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
    end else if (h_last_s) begin
      hcnt_d = 12'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : (vcnt_q + 12'd1);
    end else begin
      hcnt_d = hcnt_q + 12'd1;
      vcnt_d = vcnt_q;
    end
  end

  video_pattern_rom #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_rom (
    .pat  (pat_sel_s),
    .x    (hcnt_q),
    .y    (vcnt_q),
`ifdef PATTERN_SCROLL_EN
    .fcnt (fcnt_sel_s),
`endif
    .rgb  (rom_rgb_s)
  );

  // Output decode for the current counter state; coordinates hold their last active value.
  always_comb begin
    if (emit_s) begin
      vde_d   = active_s;
      rgb_d   = active_s ? rom_rgb_s : 24'h000000;
      hsync_d = ((hcnt_q >= HS_ON) && (hcnt_q < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vcnt_q >= VS_ON) && (vcnt_q < VS_OFF)) ? SYNC_POL : ~SYNC_POL;
      fs_d    = origin_s;
      px_d    = active_s ? hcnt_q : px_q;
      py_d    = active_s ? vcnt_q : py_q;
    end else begin
      vde_d   = 1'b0;
      rgb_d   = 24'h000000;
      hsync_d = ~SYNC_POL;
      vsync_d = ~SYNC_POL;
      fs_d    = 1'b0;
      px_d    = px_q;
      py_d    = py_q;
    end
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hcnt_q  <= 12'd0;
      vcnt_q  <= 12'd0;
      pat_q   <= 2'd0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      vde_q   <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= 24'h000000;
      px_q    <= 12'd0;
      py_q    <= 12'd0;
`ifdef PATTERN_SCROLL_EN
      fcnt_q  <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pat_q   <= pat_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vde_q   <= vde_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
      px_q    <= px_d;
      py_q    <= py_d;
`ifdef PATTERN_SCROLL_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign vid.HSync      = hsync_q;
  assign vid.VSync      = vsync_q;
  assign vid.VDE        = vde_q;
  assign vid.RGBout     = rgb_q;
  assign vid.FrameStart = fs_q;
  assign vid.PixelX     = px_q;
  assign vid.PixelY     = py_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen.
//   dut_s : tiny raster 8/2/2/2 x 4/1/1/1 (14 x 7, 98-cycle frame), bars, enable/drain, reset.
//   dut_m : 66/2/2/2 x 40/1/1/1 (72 x 43) for pattern switching, box, checker, ramp, scroll.
module tb_video_pattern_gen;

  localparam int HT_S = 14;
  localparam int HT_M = 72;
  localparam int FM   = 72 * 43;
`ifdef PATTERN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_s = 1'b1, en_s = 1'b0;
  logic       rst_m = 1'b1, en_m = 1'b0;
  logic [1:0] pat_s = 2'd0, pat_m = 2'd0;

  int checks = 0;
  int failures = 0;
  int px_s = 0, py_s = 0;
  int m_pos = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen_if vid_s ();
  video_pattern_gen_if vid_m ();

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s (.CLK(clk), .RST(rst_s), .Enable(en_s), .Pattern(pat_s), .vid(vid_s));

  video_pattern_gen #(
    .H_ACTIVE(66), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_m (.CLK(clk), .RST(rst_m), .Enable(en_m), .Pattern(pat_m), .vid(vid_m));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_m();
    step();
    m_pos++;
  endtask

  // Advance the medium DUT until its output shows pixel (x,y) of frame f.
  task automatic adv_to(input int f, input int x, input int y);
    int target;
    target = f * FM + y * HT_M + x;
    while (m_pos < target) step_m();
  endtask

  task automatic check_idle_s(input string tag, input int ex, input int ey);
    check({tag, "_vde"}, 32'(vid_s.VDE), 32'd0);
    check({tag, "_rgb"}, 32'(vid_s.RGBout), 32'd0);
    check({tag, "_fs"},  32'(vid_s.FrameStart), 32'd0);
    check({tag, "_hs"},  32'(vid_s.HSync), 32'd1);
    check({tag, "_vs"},  32'(vid_s.VSync), 32'd1);
    check({tag, "_px"},  32'(vid_s.PixelX), 32'(ex));
    check({tag, "_py"},  32'(vid_s.PixelY), 32'(ey));
  endtask

  // Step through frame positions from..to of the small DUT and check every output.
  task automatic expect_pixels_s(input int from, input int to);
    int h, v;
    logic act;
    for (int idx = from; idx <= to; idx++) begin
      step();
      h = idx % HT_S;
      v = idx / HT_S;
      act = (h < 8) && (v < 4);
      if (act) begin
        px_s = h;
        py_s = v;
      end
      check($sformatf("s_vde_%0d", idx), 32'(vid_s.VDE), 32'(act));
      check($sformatf("s_hs_%0d", idx), 32'(vid_s.HSync), 32'(!(h == 10 || h == 11)));
      check($sformatf("s_vs_%0d", idx), 32'(vid_s.VSync), 32'(v != 5));
      check($sformatf("s_rgb_%0d", idx), 32'(vid_s.RGBout), act ? 32'(bars[h % 8]) : 32'd0);
      check($sformatf("s_fs_%0d", idx), 32'(vid_s.FrameStart), 32'(idx == 0));
      check($sformatf("s_px_%0d", idx), 32'(vid_s.PixelX), 32'(px_s));
      check($sformatf("s_py_%0d", idx), 32'(vid_s.PixelY), 32'(py_s));
    end
  endtask

  initial begin
    // ---------------- small raster ----------------
    step();
    step();
    check_idle_s("s_rst", 0, 0);
    rst_s = 1'b0;
    step();
    check_idle_s("s_idle0", 0, 0);
    en_s = 1'b1;
    expect_pixels_s(0, 97);          // full frame, pixel (0,0) one cycle after enable
    expect_pixels_s(0, 17);          // next frame back-to-back, up to pixel (3,1)
    en_s = 1'b0;
    expect_pixels_s(18, 97);         // drain completes the frame
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle_s($sformatf("s_drained%0d", i), 7, 3);
    end
    en_s = 1'b1;
    expect_pixels_s(0, 33);          // restart, up to pixel (5,2)
    rst_s = 1'b1;
    step();
    check_idle_s("s_midrst", 0, 0);
    rst_s = 1'b0;
    px_s = 0;
    py_s = 0;
    expect_pixels_s(0, 15);

    // ---------------- medium raster ----------------
    check("m_rst_vde", 32'(vid_m.VDE), 32'd0);
    check("m_rst_hs", 32'(vid_m.HSync), 32'd1);
    check("m_rst_rgb", 32'(vid_m.RGBout), 32'd0);
    rst_m = 1'b0;
    en_m  = 1'b1;
    pat_m = 2'd0;
    m_pos = -1;
    adv_to(0, 0, 0);
    check("m_f0_fs", 32'(vid_m.FrameStart), 32'd1);
    check("m_f0_rgb00", 32'(vid_m.RGBout), 32'hFFFFFF);
    adv_to(0, 8, 5);   check("m_bar1", 32'(vid_m.RGBout), 32'hFFFF00);
    adv_to(0, 55, 5);  check("m_bar6", 32'(vid_m.RGBout), 32'h0000FF);
    adv_to(0, 56, 5);  check("m_bar7a", 32'(vid_m.RGBout), 32'h000000);
    adv_to(0, 65, 5);  check("m_bar7_rem", 32'(vid_m.RGBout), 32'h000000);
    check("m_px65", 32'(vid_m.PixelX), 32'd65);
    adv_to(0, 68, 5);  check("m_hs_on", 32'(vid_m.HSync), 32'd0);
    adv_to(0, 20, 10);
    pat_m = 2'd3;
    adv_to(0, 30, 20); check("m_midframe_bars", 32'(vid_m.RGBout), 32'h00FF00);
    adv_to(1, 0, 0);   check("m_f1_fs", 32'(vid_m.FrameStart), 32'd1);
    adv_to(1, 20, 9);  check("m_box_above", 32'(vid_m.RGBout), 32'h000000);
    adv_to(1, 14, 10); check("m_box_left", 32'(vid_m.RGBout), 32'h000000);
    adv_to(1, 15, 10); check("m_box_15", 32'(vid_m.RGBout), (SCROLL != 0) ? 32'hFFFFFF : 32'h000000);
    adv_to(1, 16, 10); check("m_box_corner", 32'(vid_m.RGBout), 32'hFFFFFF);
    adv_to(1, 49, 10); check("m_box_right", 32'(vid_m.RGBout), 32'h000000);
    adv_to(1, 66, 10);
    check("m_blank_vde", 32'(vid_m.VDE), 32'd0);
    check("m_blank_rgb", 32'(vid_m.RGBout), 32'h000000);
    check("m_blank_px", 32'(vid_m.PixelX), 32'd65);
    adv_to(1, 47, 29); check("m_box_inner", 32'(vid_m.RGBout), 32'hFFFFFF);
    adv_to(1, 20, 30); check("m_box_below", 32'(vid_m.RGBout), 32'h000000);
    adv_to(1, 50, 35);
    pat_m = 2'd1;
    adv_to(2, 29, 0);  check("m_chk_29_0", 32'(vid_m.RGBout), 32'hFFFFFF);
    adv_to(2, 30, 0);  check("m_chk_30_0", 32'(vid_m.RGBout), (SCROLL != 0) ? 32'h000000 : 32'hFFFFFF);
    adv_to(2, 33, 0);  check("m_chk_33_0", 32'(vid_m.RGBout), 32'h000000);
    adv_to(2, 0, 32);  check("m_chk_0_32", 32'(vid_m.RGBout), 32'h000000);
    adv_to(2, 33, 32); check("m_chk_33_32", 32'(vid_m.RGBout), 32'hFFFFFF);
    adv_to(2, 40, 35);
    pat_m = 2'd2;
    adv_to(3, 10, 0);  check("m_ramp_f3_10", 32'(vid_m.RGBout), (SCROLL != 0) ? 32'h0D0D0D : 32'h0A0A0A);
    adv_to(3, 65, 0);  check("m_ramp_f3_65", 32'(vid_m.RGBout), (SCROLL != 0) ? 32'h444444 : 32'h414141);
    adv_to(3, 5, 2);
    rst_m = 1'b1;
    step();
    check("m_rst_mid_vde", 32'(vid_m.VDE), 32'd0);
    check("m_rst_mid_px", 32'(vid_m.PixelX), 32'd0);
    check("m_rst_mid_fs", 32'(vid_m.FrameStart), 32'd0);
    rst_m = 1'b0;
    m_pos = -1;
    adv_to(0, 0, 0);
    check("m_rst_restart_fs", 32'(vid_m.FrameStart), 32'd1);
    check("m_rst_restart_py", 32'(vid_m.PixelY), 32'd0);
    adv_to(0, 10, 0);  check("m_ramp_f0_10", 32'(vid_m.RGBout), 32'h0A0A0A);
    adv_to(3, 10, 0);  check("m_ramp_f3b_10", 32'(vid_m.RGBout), (SCROLL != 0) ? 32'h0D0D0D : 32'h0A0A0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
